instr_fetch: RTL and testbench

Instruction fetch/issue unit feeding the multicycle controller. Reads 16-bit instructions from program memory at PC and presents each one as `fncode` while the controller sits in its initial state (5'b00000). It tracks the controller back to the initial state and then advances the PC: PC+1, or the branch target reported by the datapath. It is the producer side of the `fncode`/controller-state interface that the next-state logic consumes.

---
 rtl/ifetch_pkg.sv | 28 ++
 rtl/ifetch_decode.sv | 27 ++
 rtl/instr_fetch.sv | 137 +++++++++++++
 tb/tb_instr_fetch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch/issue unit:
// FSM encoding, opcode map and the controller's idle-state code.
package ifetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] OP_LOAD    = 4'h0;
  localparam logic [3:0] OP_STORE   = 4'h1;
  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_BRANCH  = 4'h3;
  localparam logic [3:0] OP_ADD     = 4'h4;
  localparam logic [3:0] OP_XOR     = 4'h5;
  localparam logic [3:0] OP_AND     = 4'h6;
  localparam logic [3:0] OP_OR      = 4'h7;
  localparam logic [3:0] OP_SUB     = 4'h8;
  localparam logic [3:0] OP_NOT     = 4'h9;
  localparam logic [3:0] OP_ONESALL = 4'hA;
  localparam logic [3:0] OP_HALT    = 4'hF;

  localparam logic [4:0] CTRL_IDLE = 5'b00000;

endpackage

// File: rtl/ifetch_decode.sv
// Combinational opcode classifier: exactly one of legal/halt/illegal is set.
// Kept standalone so a disassembler or trace unit can reuse it.
module ifetch_decode
  import ifetch_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       legal,
  output logic       halt,
  output logic       illegal
);

  // NOTE: every output gets a default before the if-chain so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    legal   = 1'b0;
    halt    = 1'b0;
    illegal = 1'b0;
    if (opcode == OP_HALT) begin
      halt = 1'b1;
    end else if (opcode <= OP_ONESALL) begin
      legal = 1'b1;
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/issue unit: fetches at pc, presents fncode to the controller,
// then advances pc (pc+1 or a taken branch target). Optional: IFETCH_ILLEGAL_TRAP_EN.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_data,
  input  logic               mem_valid,
  output logic [INSTR_W-1:0] fncode,
  output logic               instr_valid,
  input  logic [4:0]         ctrl_state,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               illegal
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_inc, target_q;
  logic [INSTR_W-1:0] fncode_q;
  logic               sticky_q;
  logic               op_legal, op_halt, op_illegal;

  ifetch_decode u_decode (
    .opcode  (mem_data[INSTR_W-1:INSTR_W-4]),
    .legal   (op_legal),
    .halt    (op_halt),
    .illegal (op_illegal)
  );

  // Wraps modulo 2^ADDR_W by construction.
  assign pc_inc = pc_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_valid) begin
          if (op_halt) begin
            state_d = ST_HALT;
          end else if (op_legal) begin
            state_d = ST_ISSUE;
          end else if (op_illegal) begin
`ifdef IFETCH_ILLEGAL_TRAP_EN
            state_d = ST_HALT;
`else
            state_d = ST_FETCH;
`endif
          end
        end
      end
      ST_ISSUE: if (ctrl_state != CTRL_IDLE) state_d = ST_EXEC;
      ST_EXEC:  if (ctrl_state == CTRL_IDLE) state_d = ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef IFETCH_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (state_q == ST_FETCH && mem_valid && op_illegal) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
  assign halted  = (state_q == ST_HALT) && !illegal_q;
`else
  assign illegal = 1'b0;
  assign halted  = (state_q == ST_HALT);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= '0;
      fncode_q <= '0;
      target_q <= '0;
      sticky_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (mem_valid) begin
            fncode_q <= mem_data;
`ifndef IFETCH_ILLEGAL_TRAP_EN
            // Skipped illegal opcodes are never issued; move straight on.
            if (op_illegal) pc_q <= pc_inc;
`endif
          end
        end
        ST_EXEC: begin
          if (branch_taken) begin
            sticky_q <= 1'b1;
            target_q <= branch_target;
          end
          // A branch resolved in the return cycle itself still wins.
          if (ctrl_state == CTRL_IDLE) begin
            if (branch_taken)  pc_q <= branch_target;
            else if (sticky_q) pc_q <= target_q;
            else               pc_q <= pc_inc;
            sticky_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_rd      = (state_q == ST_FETCH);
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign fncode      = fncode_q;
  assign instr_valid = (state_q == ST_ISSUE);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed table of fetch transactions,
// hand-written reset/illegal sequences, and randomized programs vs. a PC model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n, start, mem_rd, mem_valid, instr_valid;
  logic        branch_taken, halted, illegal;
  logic [7:0]  mem_addr, branch_target, pc;
  logic [15:0] mem_data, fncode;
  logic [4:0]  ctrl_state;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(8), .INSTR_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_valid     (mem_valid),
    .fncode        (fncode),
    .instr_valid   (instr_valid),
    .ctrl_state    (ctrl_state),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .halted        (halted),
    .illegal       (illegal)
  );

  typedef struct {
    logic [15:0] data;
    int          wait_n;
    int          hold_n;
    int          exec_n;
    logic [31:0] mask;
    logic [7:0]  base;
    logic [7:0]  addr;
    bit          issue;
    bit          halt;
    bit          ill;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] d, input int w, input int h, input int e,
                              input logic [31:0] m, input logic [7:0] b, input logic [7:0] a,
                              input bit iss, input bit hlt, input bit ill);
    vec_t v;
    v.data = d; v.wait_n = w; v.hold_n = h; v.exec_n = e; v.mask = m; v.base = b;
    v.addr = a; v.issue = iss; v.halt = hlt; v.ill = ill;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_rd"},      mem_rd,      0);
    check({tag, "_mem_addr"},    mem_addr,    0);
    check({tag, "_fncode"},      fncode,      0);
    check({tag, "_instr_valid"}, instr_valid, 0);
    check({tag, "_halted"},      halted,      0);
    check({tag, "_illegal"},     illegal,     0);
    check({tag, "_pc"},          pc,          0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; mem_valid = 1'b0; mem_data = '0;
    ctrl_state = '0; branch_taken = 1'b0; branch_target = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One fetch transaction; entered and left at a negedge with the DUT in FETCH
  // (or HALT for a halting instruction). Branch pulse k carries target base+k.
  task automatic fetch_one(input vec_t v);
    check("fetch_rd",   mem_rd,   1);
    check("fetch_addr", mem_addr, v.addr);
    for (int w = 0; w < v.wait_n; w++) begin
      mem_valid = 1'b0;
      @(negedge clk);
      check("wait_rd",   mem_rd,      1);
      check("wait_addr", mem_addr,    v.addr);
      check("wait_iv",   instr_valid, 0);
    end
    mem_valid = 1'b1;
    mem_data  = v.data;
    @(negedge clk);
    mem_valid = 1'b0;
    mem_data  = 16'($urandom);
    if (v.halt) begin
      check("halt_halted",  halted,      !v.ill);
      check("halt_illegal", illegal,     v.ill);
      check("halt_pc",      pc,          v.addr);
      check("halt_rd",      mem_rd,      0);
      check("halt_iv",      instr_valid, 0);
      return;
    end
    if (!v.issue) begin
      check("skip_iv", instr_valid, 0);
      check("skip_rd", mem_rd,      1);
      return;
    end
    check("issue_iv", instr_valid, 1);
    check("issue_fn", fncode,      v.data);
    for (int h = 0; h < v.hold_n; h++) begin
      ctrl_state = '0;
      @(negedge clk);
      check("hold_iv", instr_valid, 1);
      check("hold_fn", fncode,      v.data);
    end
    ctrl_state = 5'd1;
    @(negedge clk);
    for (int k = 0; k <= v.exec_n; k++) begin
      check("exec_iv", instr_valid, 0);
      check("exec_fn", fncode,      v.data);
      check("exec_pc", pc,          v.addr);
      ctrl_state    = (k == v.exec_n) ? 5'd0 : 5'(k + 2);
      branch_taken  = v.mask[k];
      branch_target = v.mask[k] ? v.base + 8'(k) : 8'($urandom);
      @(negedge clk);
    end
    branch_taken = 1'b0;
    ctrl_state   = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[$];
    logic [15:0] prog[256];
    logic [7:0]  mpc, nxt;
    bit          is_ill;
    vec_t        v;

    // Reset state and IDLE holding without start.
    do_reset();
    check_reset_outputs("reset");
    @(negedge clk);
    check("idle_rd", mem_rd, 0);

    // Short program: add, xor, halt.
    kick();
    fetch_one(mk(16'h4012, 0, 0, 2, 0, 8'h00, 8'h00, 1, 0, 0));
    fetch_one(mk(16'h5123, 0, 0, 1, 0, 8'h00, 8'h01, 1, 0, 0));
    fetch_one(mk(16'hF000, 0, 0, 0, 0, 8'h00, 8'h02, 0, 1, 0));
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("halt_absorb", halted, 1);
    check("halt_absorb_rd", mem_rd, 0);

    // Directed table: waits, branches (taken / not taken / overwrite / return-cycle), wrap.
    tbl.push_back(mk(16'h4012, 0, 0, 2, 32'b000, 8'h00, 8'h00, 1, 0, 0));
    tbl.push_back(mk(16'h5123, 3, 1, 1, 32'b000, 8'h00, 8'h01, 1, 0, 0));
    tbl.push_back(mk(16'h3000, 0, 0, 3, 32'b001, 8'h05, 8'h02, 1, 0, 0));
    tbl.push_back(mk(16'h3111, 0, 0, 2, 32'b000, 8'h20, 8'h05, 1, 0, 0));
    tbl.push_back(mk(16'h3abc, 0, 0, 1, 32'b001, 8'h05, 8'h06, 1, 0, 0));
    tbl.push_back(mk(16'h3111, 0, 0, 2, 32'b001, 8'h20, 8'h05, 1, 0, 0));
    tbl.push_back(mk(16'h3222, 1, 0, 2, 32'b101, 8'h40, 8'h20, 1, 0, 0));
    tbl.push_back(mk(16'h3333, 0, 0, 1, 32'b010, 8'hFE, 8'h42, 1, 0, 0));
    tbl.push_back(mk(16'h4444, 0, 0, 0, 32'b000, 8'h00, 8'hFF, 1, 0, 0));
    tbl.push_back(mk(16'h6001, 2, 0, 3, 32'b000, 8'h00, 8'h00, 1, 0, 0));
    tbl.push_back(mk(16'hF000, 0, 0, 0, 32'b000, 8'h00, 8'h01, 0, 1, 0));
    do_reset();
    kick();
    for (int i = 0; i < tbl.size(); i++) fetch_one(tbl[i]);

    // Illegal opcode at pc=3.
    do_reset();
    kick();
    fetch_one(mk(16'h3000, 0, 0, 1, 32'b001, 8'h03, 8'h00, 1, 0, 0));
`ifdef IFETCH_ILLEGAL_TRAP_EN
    fetch_one(mk(16'hC123, 0, 0, 0, 0, 8'h00, 8'h03, 0, 1, 1));
    repeat (2) @(negedge clk);
    check("trap_sticky_illegal", illegal, 1);
    check("trap_pc", pc, 8'h03);
`else
    fetch_one(mk(16'hC123, 1, 0, 0, 0, 8'h00, 8'h03, 0, 0, 0));
    fetch_one(mk(16'hF000, 0, 0, 0, 0, 8'h00, 8'h04, 0, 1, 0));
    check("skip_illegal_flag", illegal, 0);
`endif

    // Reset during EXEC with a branch pending in the same cycle.
    do_reset();
    kick();
    mem_valid = 1'b1; mem_data = 16'h4abc;
    @(negedge clk);
    mem_valid = 1'b0;
    ctrl_state = 5'd1;
    @(negedge clk);
    check("pre_rst_exec_iv", instr_valid, 0);
    branch_taken = 1'b1; branch_target = 8'h77; ctrl_state = 5'd3; rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_exec");
    rst_n = 1'b1; branch_taken = 1'b0; ctrl_state = '0;
    @(negedge clk);
    check("rst_exec_idle_rd", mem_rd, 0);
    kick();
    fetch_one(mk(16'h4012, 0, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0));
    check("rst_exec_no_stale_branch", mem_addr, 8'h01);

    // Reset during an outstanding read, with mem_valid in the same cycle.
    mem_valid = 1'b1; mem_data = 16'h5555; rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_read");
    mem_valid = 1'b0; rst_n = 1'b1;
    kick();
    fetch_one(mk(16'hF000, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0));

    // Randomized programs against a transaction-level PC model.
    for (int i = 0; i < 256; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 10));
`ifndef IFETCH_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(11, 14));
`endif
      prog[i] = {op, 12'($urandom)};
    end
    do_reset();
    kick();
    mpc = 8'h00;
    for (int n = 0; n < 150; n++) begin
      v.data   = prog[mpc];
      v.addr   = mpc;
      v.wait_n = $urandom_range(0, 3);
      v.hold_n = $urandom_range(0, 1);
      v.exec_n = $urandom_range(0, 4);
      v.mask   = ($urandom_range(0, 1) == 1) ? ($urandom & ((32'd1 << (v.exec_n + 1)) - 1)) : 32'd0;
      v.base   = 8'($urandom);
      v.halt   = 1'b0;
      v.ill    = 1'b0;
      is_ill   = (prog[mpc][15:12] >= 4'hB) && (prog[mpc][15:12] <= 4'hE);
      v.issue  = !is_ill;
      nxt = mpc + 8'd1;
      if (!is_ill) begin
        for (int k = 0; k <= v.exec_n; k++) if (v.mask[k]) nxt = v.base + 8'(k);
      end
      fetch_one(v);
      mpc = nxt;
    end
    check("rand_final_addr", mem_addr, mpc);
    check("rand_final_rd",   mem_rd,   1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
